// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared FSM type, index sizing and pointer-wrap helper for mem_bus_ctrl
package mem_bus_ctrl_pkg;

   localparam int MAX_REQ = 8;
   localparam int IDX_W   = $clog2(MAX_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_ADDR = 2'd2,
      RD_DATA = 2'd3
   } state_t;

   // v is at most 2*n-1 here, so a single conditional subtract is a full modulo
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] v, input int n);
      return (v >= (IDX_W+1)'(n)) ? IDX_W'(v - (IDX_W+1)'(n)) : IDX_W'(v);
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - requester handshake, read response and memory control strobes of mem_bus_ctrl
interface mem_bus_ctrl_if #(
   parameter int NUM_REQ       = 2,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8
);

   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ-1:0]               req_we;
   logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata;
   logic [NUM_REQ-1:0]               rsp_valid;
   logic [DATA_WIDTH-1:0]            rsp_rdata;
   logic                             mem_sel;
   logic                             mem_w_en;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, mem_sel, mem_w_en
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_sel, mem_w_en
   );

endinterface

// File: rtl/mem_bus_ctrl_rr_arbiter.sv
// rtl/mem_bus_ctrl_rr_arbiter.sv - combinational round-robin pick starting one past the last winner
module rr_arbiter
   import mem_bus_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [MAX_REQ-1:0] w_req_pad;
   logic [IDX_W-1:0]   w_cand;

   assign w_req_pad = MAX_REQ'(i_req);

   // Scan farthest-first so the candidate closest after the pointer is the last to overwrite
   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = wrap_idx({1'b0, i_ptr} + (IDX_W+1)'(k), NUM_REQ);
         if (w_req_pad[w_cand]) begin
            o_gnt = NUM_REQ'(1) << w_cand;
            o_idx = w_cand;
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - arbitrated master for one shared single-port tri-state memory; MEM_BUS_CTRL_PRIO_EN gives requester 0 strict priority
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   mem_bus_ctrl_if.master           bus,
   inout  wire  [ADDRESS_WIDTH-1:0] address_bus,
   inout  wire  [DATA_WIDTH-1:0]    data_bus
);

   state_t                   r_state;
   state_t                   w_next_state;
   logic [IDX_W-1:0]         r_ptr;
   logic [IDX_W-1:0]         r_idx;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic [NUM_REQ-1:0]       r_rsp_valid;
   logic [DATA_WIDTH-1:0]    r_rsp_rdata;

   logic [NUM_REQ-1:0]       w_arb_req;
   logic [NUM_REQ-1:0]       w_arb_gnt;
   logic [IDX_W-1:0]         w_arb_idx;
   logic                     w_arb_any;
   logic [NUM_REQ-1:0]       w_gnt;
   logic [IDX_W-1:0]         w_win_idx;
   logic                     w_any;
   logic                     w_ptr_upd;
   logic                     w_win_we;
   logic [ADDRESS_WIDTH-1:0] w_win_addr;
   logic [DATA_WIDTH-1:0]    w_win_wdata;
   logic                     w_idle;
   logic                     w_sel;
   logic                     w_wen;
   logic                     w_drive_data;
   logic                     w_sel_out;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_req (w_arb_req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

`ifdef MEM_BUS_CTRL_PRIO_EN
   // Requester 0 bypasses the rotation entirely and leaves the pointer alone
   assign w_arb_req = bus.req_valid & ~NUM_REQ'(1);

   always_comb begin
      w_gnt     = w_arb_gnt;
      w_win_idx = w_arb_idx;
      w_any     = w_arb_any;
      w_ptr_upd = w_arb_any;
      if (bus.req_valid[0]) begin
         w_gnt     = NUM_REQ'(1);
         w_win_idx = '0;
         w_any     = 1'b1;
         w_ptr_upd = 1'b0;
      end
   end
`else
   assign w_arb_req = bus.req_valid;
   assign w_gnt     = w_arb_gnt;
   assign w_win_idx = w_arb_idx;
   assign w_any     = w_arb_any;
   assign w_ptr_upd = w_arb_any;
`endif

   always_comb begin
      w_win_we    = 1'b0;
      w_win_addr  = '0;
      w_win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_win_we    = bus.req_we[i];
            w_win_addr  = bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            w_win_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_sel        = 1'b0;
      w_wen        = 1'b0;
      w_drive_data = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_next_state = w_win_we ? WR : RD_ADDR;
            end
         end
         WR: begin
            w_sel        = 1'b1;
            w_wen        = 1'b1;
            w_drive_data = 1'b1;
            w_next_state = IDLE;
         end
         RD_ADDR: begin
            w_sel        = 1'b1;
            w_next_state = RD_DATA;
         end
         RD_DATA: begin
            w_sel        = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Reset masks grants and strobes immediately so nothing reaches the memory in the reset cycle
   assign w_idle    = (r_state == IDLE) && !rst;
   assign w_sel_out = w_sel && !rst;

   assign bus.req_ready = w_idle ? w_gnt : '0;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.mem_sel   = w_sel_out;
   assign bus.mem_w_en  = w_wen && !rst;

   assign address_bus = w_sel_out ? r_addr : 'z;
   assign data_bus    = (w_drive_data && !rst) ? r_wdata : 'z;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= IDX_W'(NUM_REQ - 1);
         r_idx       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_next_state;
         r_rsp_valid <= '0;
         if (r_state == IDLE && w_any) begin
            r_idx   <= w_win_idx;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            if (w_ptr_upd) begin
               r_ptr <= w_win_idx;
            end
         end
         if (r_state == RD_DATA) begin
            r_rsp_valid <= NUM_REQ'(1) << r_idx;
            r_rsp_rdata <= data_bus;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl with a behavioural tri-state memory
module tb_mem_bus_ctrl;

   localparam int NR = 2;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NV = 13;

   typedef struct {
      int             r;
      logic           we;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  wdata;
      logic [DW-1:0]  exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   wire  [AW-1:0] address_bus;
   wire  [DW-1:0] data_bus;

   int n_pass  = 0;
   int n_total = 0;
   int sel_cycles = 0;
   int wen_cycles = 0;
   int nw = 0;
   int nr = 0;
   logic mon_en = 1'b0;

   logic [DW-1:0] mem_arr [256];
   logic [DW-1:0] m_dout;
   logic          m_drive;
   logic [DW-1:0] shadow [256];

   mem_bus_ctrl_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   mem_bus_ctrl #(
      .NUM_REQ       (NR),
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .address_bus (address_bus),
      .data_bus    (data_bus)
   );

   always #5 clk = ~clk;

   // Memory: loads d_out on the address cycle, drives it on the following cycle
   assign data_bus = (m_drive && bus.mem_sel && !bus.mem_w_en) ? m_dout : 'z;

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      m_dout  = '0;
      m_drive = 1'b0;
      forever begin
         @(posedge clk);
         if (bus.mem_sel && bus.mem_w_en) mem_arr[address_bus] <= data_bus;
         else if (bus.mem_sel) m_dout <= mem_arr[address_bus];
         m_drive <= bus.mem_sel && !bus.mem_w_en && !m_drive && !rst;
      end
   end

   always @(negedge clk) begin
      if (mon_en && bus.mem_sel) sel_cycles++;
      if (mon_en && bus.mem_w_en) wen_cycles++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: actual %h required %h", nm, tag, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic transact(input int r, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp, input int tag);
      int waited;
      step();
      bus.req_valid = NR'(1) << r;
      bus.req_we    = we ? (NR'(1) << r) : '0;
      bus.req_addr  = (NR*AW)'(a) << (r*AW);
      bus.req_wdata = (NR*DW)'(wd) << (r*DW);
      #1;
      waited = 0;
      while ((bus.req_ready & (NR'(1) << r)) == '0 && waited < 20) begin
         step();
         waited++;
      end
      chk("grant", tag, 32'(bus.req_ready), 32'(1) << r);
      if (we) shadow[a] = wd;
      if (mon_en) begin
         if (we) nw++;
         else nr++;
      end
      step();
      bus.req_valid = '0;
      chk("sel_c1", tag, 32'(bus.mem_sel), 32'd1);
      chk("wen_c1", tag, 32'(bus.mem_w_en), 32'(we));
      if (we) begin
         step();
         chk("sel_after_wr", tag, 32'(bus.mem_sel), 32'd0);
      end else begin
         step();
         chk("sel_c2", tag, 32'(bus.mem_sel), 32'd1);
         chk("rsp_early", tag, 32'(bus.rsp_valid), 32'd0);
         step();
         chk("rsp_valid", tag, 32'(bus.rsp_valid), 32'(1) << r);
         chk("rsp_rdata", tag, bus.rsp_rdata, exp);
         step();
         chk("rsp_pulse", tag, 32'(bus.rsp_valid), 32'd0);
         chk("rdata_hold", tag, bus.rsp_rdata, exp);
      end
   endtask

   initial begin
      vec_t vecs [NV];
      int   exp_order [4];
      int   q [$];
      int   gcount;
      int   g;
      int   er;
      int   rr;
      logic rwe;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;

      vecs[0]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{0, 1'b1, 8'h00, 32'hFFFFFFFF, 32'h0};
      vecs[3]  = '{0, 1'b1, 8'hFF, 32'h00000000, 32'h0};
      vecs[4]  = '{0, 1'b0, 8'h00, 32'h0,        32'hFFFFFFFF};
      vecs[5]  = '{0, 1'b0, 8'hFF, 32'h0,        32'h00000000};
      vecs[6]  = '{1, 1'b1, 8'h00, 32'h00000000, 32'h0};
      vecs[7]  = '{1, 1'b1, 8'hFF, 32'hFFFFFFFF, 32'h0};
      vecs[8]  = '{1, 1'b0, 8'h00, 32'h0,        32'h00000000};
      vecs[9]  = '{1, 1'b0, 8'hFF, 32'h0,        32'hFFFFFFFF};
      vecs[10] = '{1, 1'b1, 8'h20, 32'hCAFEF00D, 32'h0};
      vecs[11] = '{0, 1'b1, 8'h40, 32'h00004040, 32'h0};
      vecs[12] = '{1, 1'b1, 8'h41, 32'h41414141, 32'h0};

`ifdef MEM_BUS_CTRL_PRIO_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif

      for (int i = 0; i < 256; i++) shadow[i] = '0;
      rst           = 1'b1;
      bus.req_valid = '1;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) step();
      chk("rst_ready", 0, 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 0, 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 0, bus.rsp_rdata, 32'd0);
      chk("rst_sel", 0, 32'(bus.mem_sel), 32'd0);
      chk("rst_wen", 0, 32'(bus.mem_w_en), 32'd0);
      bus.req_valid = '0;
      rst = 1'b0;

      for (int i = 0; i < NV; i++)
         transact(vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, i);

      // Both requesters read continuously from reset release
      step();
      rst           = 1'b1;
      bus.req_valid = '1;
      bus.req_we    = '0;
      bus.req_addr  = {8'h41, 8'h40};
      step();
      rst = 1'b0;
      #1;
      gcount = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.rsp_valid != '0) begin
            if (q.size() == 0) begin
               chk("cont_rsp_spurious", c, 32'(bus.rsp_valid), 32'd0);
            end else begin
               er = q.pop_front();
               chk("cont_rsp_idx", c, 32'(bus.rsp_valid), 32'(1) << er);
               chk("cont_rsp_data", c, bus.rsp_rdata, (er == 0) ? 32'h00004040 : 32'h41414141);
            end
         end
         if (bus.req_ready != '0) begin
            g = (bus.req_ready == 2'b01) ? 0 : (bus.req_ready == 2'b10) ? 1 : -1;
            if (gcount < 4) chk("cont_order", gcount, 32'(g), 32'(exp_order[gcount]));
            q.push_back(g);
            gcount++;
         end
         step();
      end
      bus.req_valid = '0;
      repeat (5) step();
      chk("cont_grants", 0, 32'(gcount >= 4), 32'd1);

      // Reset while the read sits in its address cycle
      bus.req_valid = 2'b01;
      bus.req_we    = '0;
      bus.req_addr  = {8'h00, 8'h20};
      #1;
      chk("rrd_grant", 0, 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = '0;
      rst = 1'b1;
      #1;
      chk("rrd_sel_in_rst", 0, 32'(bus.mem_sel), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rrd_sel_after", 0, 32'(bus.mem_sel), 32'd0);
      chk("rrd_rsp_a", 0, 32'(bus.rsp_valid), 32'd0);
      step();
      chk("rrd_rsp_b", 0, 32'(bus.rsp_valid), 32'd0);
      chk("rrd_sel_b", 0, 32'(bus.mem_sel), 32'd0);
      step();
      chk("rrd_rsp_c", 0, 32'(bus.rsp_valid), 32'd0);
      transact(0, 1'b0, 8'h20, 32'h0, 32'hCAFEF00D, 50);

      // Reset during a write handshake cycle suppresses the write
      step();
      rst           = 1'b1;
      bus.req_valid = 2'b01;
      bus.req_we    = 2'b01;
      bus.req_addr  = {8'h00, 8'h20};
      bus.req_wdata = {32'h0, 32'h0BADBAD0};
      #1;
      chk("rwr_ready", 0, 32'(bus.req_ready), 32'd0);
      step();
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_we    = '0;
      transact(0, 1'b0, 8'h20, 32'h0, 32'hCAFEF00D, 51);

      // Random traffic under the strobe monitor
      mon_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         rr  = int'($urandom_range(0, 1));
         rwe = 1'($urandom_range(0, 1));
         ra  = 8'h80 + 8'($urandom_range(0, 7));
         rd  = $urandom;
         transact(rr, rwe, ra, rd, shadow[ra], 100 + k);
      end
      mon_en = 1'b0;
      chk("mon_sel_cycles", 0, 32'(sel_cycles), 32'(nw + 2 * nr));
      chk("mon_wen_cycles", 0, 32'(wen_cycles), 32'(nw));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
